pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers plus PC). It detects load-use hazards, applies taken-branch flushes, and runs the data-memory req/ready handshake. While a memory access is pending it freezes the upstream stages and bubbles the MEM/WB register. A small FSM adds wait-state timeout detection (halt on timeout) and saturating stall/flush statistics counters.

Parameters:
REG_AW, 5, register address width
TIMEOUT, 16, max MEM_WAIT cycles before HALT (>=1)
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
id_rs  in  REG_AW  ID-stage source reg 1
id_rt  in  REG_AW  ID-stage source reg 2
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
ex_memread  in  1  EX-stage instruction is a load
ex_rd  in  REG_AW  EX-stage destination reg
ex_branch_taken  in  1  EX-stage branch/jump resolved taken
mem_rd  in  1  MEM-stage load
mem_wr  in  1  MEM-stage store
dmem_ready  in  1  data memory completes access this cycle
dmem_req  out  1  data memory request
pc_en  out  1  PC write enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID sync clear
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX sync clear
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
memwb_flush  out  1  MEM/WB sync clear
halted  out  1  sticky timeout flag
stall_cnt  out  CNT_W  cycles with any stall
flush_cnt  out  CNT_W  branch flush events

Behaviour:
- Flush overrides enable at the consuming register; the flush takes effect on the next clk edge.
- The stage-control outputs are combinational from state and inputs.
- Reset (async, any state, including mid-MEM_WAIT): state=RUN, wait_ctr=0, halted=0, stall_cnt=0, flush_cnt=0, dmem_req=0.
- While rst is high: all *_en=0, all *_flush=1.
- mem_acc = mem_rd|mem_wr.
- mem_stall = mem_acc & ~dmem_ready, in state RUN or MEM_WAIT.
- load_use = ex_memread & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- Default (RUN or MEM_WAIT): dmem_req=mem_acc; all *_en=1; all *_flush=0.
- Priority 1, mem_stall: pc_en=ifid_en=idex_en=exmem_en=0 and memwb_flush=1. Branch and load-use are held and not applied.
- Priority 2, ex_branch_taken: ifid_flush=1, idex_flush=1, pc_en=1 (PC takes target). Branch wins over a simultaneous load_use, because the ID instruction is discarded.
- Priority 3, load_use: pc_en=0, ifid_en=0, idex_flush=1. EX/MEM and MEM/WB advance. Exactly 1 bubble per hazard.
- Zero-wait access: dmem_ready is high in the same cycle as the request. No stall; the state stays RUN.
- FSM transitions:
  - RUN -> MEM_WAIT on mem_stall, wait_ctr<=1.
  - MEM_WAIT with mem_stall: wait_ctr++. When wait_ctr==TIMEOUT and still ~dmem_ready -> HALT.
  - MEM_WAIT with dmem_ready: apply priorities 2/3 normally that cycle, -> RUN, wait_ctr<=0.
  - A new access in the cycle after completion re-enters MEM_WAIT if not ready.
- HALT: dmem_req=0, all *_en=0, memwb_flush=1, halted=1. Leaves only via rst. dmem_ready is ignored.
- dmem_req stays high continuously from assertion until the ready cycle. mem_rd/mem_wr must be stable during the wait (frozen EX/MEM guarantees this).
- stall_cnt increments each cycle with mem_stall or (load_use & ~ex_branch_taken & ~mem_stall), and also in HALT.
- flush_cnt increments on each applied branch flush.
- Both counters saturate at all-ones and do not wrap.

Decomposition:
- Shared package (pipe_pkg) holds:
  - the FSM state enum {RUN, MEM_WAIT, HALT}
  - the REG_AW constant
  - a stage_ctrl_t struct {en, flush}, reused by other controllers
- One natural sub-module: hazard_detect. It is combinational: load_use from ID/EX fields. It is also reusable by the forwarding unit.
- Counters and FSM stay in the top level.

Test Plan:
- Load-use: EX lw $3, ID add using rt=$3 -> 1 cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle all en=1; stall_cnt=1.
- Branch: ex_branch_taken=1 with load_use also true -> ifid_flush=idex_flush=1, pc_en=1, no stall; flush_cnt=1, stall_cnt=0.
- 3-wait load: mem_rd=1, dmem_ready low 3 cycles then high -> 3 frozen cycles with memwb_flush=1 and dmem_req high for 4 cycles; memwb_en=1 on the 4th cycle; state back to RUN; stall_cnt=3.
- Zero-wait store: mem_wr=1, dmem_ready=1 same cycle -> dmem_req=1, all en=1, state stays RUN, stall_cnt unchanged.
- Timeout with TIMEOUT=4: dmem_ready held low -> HALT after 4 wait cycles; halted=1, dmem_req=0, all en=0; a later dmem_ready=1 has no effect.
- Reset mid-MEM_WAIT, and branch pending during a memory wait:
  - Reset: rst pulses in cycle 2 of a wait -> state RUN, dmem_req=0, counters 0 immediately (async).
  - Pending branch: ex_branch_taken asserted throughout a 2-cycle wait -> flush applied only on the ready cycle; flush_cnt=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: sequencer states, register address width,
// and the per-register enable/flush pair used by the stage controllers.
package pipe_pkg;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;
endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: the EX instruction is a load whose destination is
// read by the ID instruction. Register 0 is hardwired, so it never hazards.
module hazard_detect #(
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              load_use
);
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs && (id_rs == ex_rd)) ||
                     (id_use_rt && (id_rt == ex_rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait freeze,
// branch flush, load-use bubble, wait timeout halt and statistics counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW  = pipe_pkg::REG_AW,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              dmem_ready,
  output logic              dmem_req,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              memwb_flush,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  import pipe_pkg::*;

  localparam int WW = $clog2(TIMEOUT + 1);

  state_t        state, state_nx;
  logic [WW-1:0] wait_ctr, wait_nx;
  logic          mem_acc, mem_stall, load_use, active;
  logic          stall_evt, flush_evt;
  logic          pc_c, exmem_c, req_c;
  stage_ctrl_t   ifid_c, idex_c, memwb_c;

  hazard_detect #(.REG_AW(REG_AW)) u_hd (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  assign active    = (state != HALT);
  assign mem_acc   = mem_rd | mem_wr;
  assign mem_stall = active & mem_acc & ~dmem_ready;
  // A held branch or load-use is not counted while memory freezes the pipe.
  assign stall_evt = mem_stall | (load_use & ~ex_branch_taken & ~mem_stall) | ~active;
  assign flush_evt = active & ~mem_stall & ex_branch_taken;
  assign halted    = (state == HALT);

  // Next state, wait counter and per-stage control before reset override
  always_comb begin
    state_nx = state;
    wait_nx  = wait_ctr;
    req_c    = mem_acc;
    pc_c     = 1'b1;
    exmem_c  = 1'b1;
    ifid_c   = '{en: 1'b1, flush: 1'b0};
    idex_c   = '{en: 1'b1, flush: 1'b0};
    memwb_c  = '{en: 1'b1, flush: 1'b0};
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nx = MEM_WAIT;
          wait_nx  = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_ctr == WW'(TIMEOUT)) state_nx = HALT;
          else                          wait_nx  = wait_ctr + WW'(1);
        end else begin
          state_nx = RUN;
          wait_nx  = '0;
        end
      end
      default: begin
        req_c       = 1'b0;
        pc_c        = 1'b0;
        exmem_c     = 1'b0;
        ifid_c.en   = 1'b0;
        idex_c.en   = 1'b0;
        memwb_c.en  = 1'b0;
        memwb_c.flush = 1'b1;
      end
    endcase
    if (active) begin
      if (mem_stall) begin
        pc_c          = 1'b0;
        ifid_c.en     = 1'b0;
        idex_c.en     = 1'b0;
        exmem_c       = 1'b0;
        memwb_c.flush = 1'b1;
      end else if (ex_branch_taken) begin
        ifid_c.flush = 1'b1;
        idex_c.flush = 1'b1;
      end else if (load_use) begin
        pc_c         = 1'b0;
        ifid_c.en    = 1'b0;
        idex_c.flush = 1'b1;
      end
    end
  end

  // Reset forces every register to hold-and-clear with no memory request
  always_comb begin
    if (rst) begin
      dmem_req    = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_en     = 1'b0;
      idex_flush  = 1'b1;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      memwb_flush = 1'b1;
    end else begin
      dmem_req    = req_c;
      pc_en       = pc_c;
      ifid_en     = ifid_c.en;
      ifid_flush  = ifid_c.flush;
      idex_en     = idex_c.en;
      idex_flush  = idex_c.flush;
      exmem_en    = exmem_c;
      memwb_en    = memwb_c.en;
      memwb_flush = memwb_c.flush;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_ctr <= '0;
    end else begin
      state    <= state_nx;
      wait_ctr <= wait_nx;
    end
  end

  // Saturating stall / flush statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule
